// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes diff = a - b - bin one bit per clock, LSB first,
// using a single full-subtractor slice and a registered borrow.
module serial_subtractor #(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow,
   output logic             overflow,
   output logic             zero
);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SHIFT = 2'b01,
      DONE  = 2'b10
   } state_t;

   state_t state_q, state_d;

   logic [WIDTH-1:0] opA_q, opA_d;
   logic [WIDTH-1:0] opB_q, opB_d;
   logic [WIDTH-2:0] res_q, res_d;
   logic             br_q, br_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             aMsb_q, aMsb_d;
   logic             bMsb_q, bMsb_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             borrow_q, borrow_d;
   logic             overflow_q, overflow_d;
   logic             zero_q, zero_d;

   logic             ai, bi, dBit, brNext, lastBit;
   logic [WIDTH-1:0] resNext;

   assign ai      = opA_q[0];
   assign bi      = opB_q[0];
   assign dBit    = ai ^ bi ^ br_q;
   assign brNext  = (~ai & bi) | (~(ai ^ bi) & br_q);
   assign resNext = {dBit, res_q};
   assign lastBit = (cnt_q == CNT_W'(WIDTH - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = SHIFT;
         SHIFT:   if (lastBit) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy = (state_q == SHIFT);
      done = (state_q == DONE);
   end

   // Operand capture, bit slicing and result publication happen only on the
   // IDLE->SHIFT and SHIFT->DONE transitions; everything else holds.
   always_comb begin
      opA_d      = opA_q;
      opB_d      = opB_q;
      res_d      = res_q;
      br_d       = br_q;
      cnt_d      = cnt_q;
      aMsb_d     = aMsb_q;
      bMsb_d     = bMsb_q;
      diff_d     = diff_q;
      borrow_d   = borrow_q;
      overflow_d = overflow_q;
      zero_d     = zero_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               opA_d  = a;
               opB_d  = b;
               br_d   = bin;
               cnt_d  = '0;
               res_d  = '0;
               aMsb_d = a[WIDTH-1];
               bMsb_d = b[WIDTH-1];
            end
         end
         SHIFT: begin
            opA_d = opA_q >> 1;
            opB_d = opB_q >> 1;
            br_d  = brNext;
            res_d = resNext[WIDTH-1:1];
            cnt_d = cnt_q + CNT_W'(1);
            if (lastBit) begin
               diff_d     = resNext;
               borrow_d   = brNext;
               overflow_d = (aMsb_q ^ bMsb_q) & (aMsb_q ^ dBit);
               zero_d     = (resNext == '0);
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         opA_q      <= '0;
         opB_q      <= '0;
         res_q      <= '0;
         br_q       <= 1'b0;
         cnt_q      <= '0;
         aMsb_q     <= 1'b0;
         bMsb_q     <= 1'b0;
         diff_q     <= '0;
         borrow_q   <= 1'b0;
         overflow_q <= 1'b0;
         zero_q     <= 1'b0;
      end else begin
         opA_q      <= opA_d;
         opB_q      <= opB_d;
         res_q      <= res_d;
         br_q       <= br_d;
         cnt_q      <= cnt_d;
         aMsb_q     <= aMsb_d;
         bMsb_q     <= bMsb_d;
         diff_q     <= diff_d;
         borrow_q   <= borrow_d;
         overflow_q <= overflow_d;
         zero_q     <= zero_d;
      end
   end

   assign diff     = diff_q;
   assign borrow   = borrow_q;
   assign overflow = overflow_q;
   assign zero     = zero_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=8): expected results are queued when
// an operation is launched and popped when done pulses.
module tb_serial_subtractor;

   localparam int W = 8;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [W-1:0] a, b;
   logic         bin;
   logic         busy, done, borrow, overflow, zero;
   logic [W-1:0] diff;

   typedef struct packed {
      logic [W-1:0] diff;
      logic         borrow;
      logic         overflow;
      logic         zero;
   } exp_t;

   exp_t sb[$];
   int   testsRun = 0;
   int   testsFailed = 0;

   serial_subtractor #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
      .busy(busy), .done(done), .diff(diff), .borrow(borrow),
      .overflow(overflow), .zero(zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: widened unsigned subtract for borrow, signed integer range for overflow.
   function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbin);
      exp_t       e;
      logic [W:0] full;
      int         sa, sbv, s;
      full = {1'b0, ma} - {1'b0, mb} - {{W{1'b0}}, mbin};
      sa   = int'($signed(ma));
      sbv  = int'($signed(mb));
      s    = sa - sbv - (mbin ? 1 : 0);
      e.diff     = full[W-1:0];
      e.borrow   = full[W];
      e.overflow = (s > 127) || (s < -128);
      e.zero     = (full[W-1:0] == '0);
      return e;
   endfunction

   // Drives start for one cycle at a falling edge; returns at the falling edge of cycle 1.
   task automatic startOp(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tbin);
      start = 1'b1;
      a     = ta;
      b     = tb;
      bin   = tbin;
      sb.push_back(model(ta, tb, tbin));
      @(negedge clk);
      start = 1'b0;
      a     = 8'hA5;
      b     = 8'h3C;
      bin   = ~tbin;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      start = 1'b0;
      a     = '0;
      b     = '0;
      bin   = 1'b0;
      @(negedge clk);
      testsRun++;
      if ({busy, done, borrow, overflow, zero, diff} !== '0) begin
         testsFailed++;
         $display("[TB] FAIL reset_outputs got=%b required=0", {busy, done, borrow, overflow, zero, diff});
      end
      rst_n = 1'b1;
      @(negedge clk);
      testsRun++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL reset_idle busy=%b done=%b required 0/0", busy, done);
      end
   endtask

   task automatic test_basic();
      logic [W-1:0] va[5]  = '{8'h35, 8'h12, 8'h80, 8'h5A, 8'h5A};
      logic [W-1:0] vb[5]  = '{8'h12, 8'h35, 8'h01, 8'h5A, 8'h5A};
      logic         vbi[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      exp_t         e;
      for (int v = 0; v < 5; v++) begin
         startOp(va[v], vb[v], vbi[v]);
         for (int c = 1; c <= W; c++) begin
            testsRun++;
            if (busy !== 1'b1 || done !== 1'b0) begin
               testsFailed++;
               $display("[TB] FAIL basic%0d_busy cycle %0d busy=%b done=%b required 1/0", v, c, busy, done);
            end
            @(negedge clk);
         end
         e = sb.pop_front();
         testsRun++;
         if (done !== 1'b1 || busy !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL basic%0d_done cycle %0d done=%b busy=%b required 1/0", v, W + 1, done, busy);
         end
         testsRun++;
         if ({diff, borrow, overflow, zero} !== e) begin
            testsFailed++;
            $display("[TB] FAIL basic%0d_result diff=%h b=%b o=%b z=%b required diff=%h b=%b o=%b z=%b",
                     v, diff, borrow, overflow, zero, e.diff, e.borrow, e.overflow, e.zero);
         end
         @(negedge clk);
         testsRun++;
         if (done !== 1'b0 || busy !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL basic%0d_pulse done=%b busy=%b required 0/0", v, done, busy);
         end
      end
   endtask

   task automatic test_ignore_start();
      exp_t e;
      int   doneCount = 0;
      int   doneCycle = -1;
      startOp(8'h40, 8'h10, 1'b0);
      @(negedge clk);
      @(negedge clk);
      start = 1'b1;
      a     = 8'hFF;
      b     = 8'h00;
      @(negedge clk);
      start = 1'b0;
      for (int c = 4; c < 20; c++) begin
         if (done === 1'b1) begin
            doneCount++;
            if (doneCycle < 0) doneCycle = c;
            if (doneCount == 1) begin
               e = sb.pop_front();
               testsRun++;
               if ({diff, borrow, overflow, zero} !== e) begin
                  testsFailed++;
                  $display("[TB] FAIL ignore_result diff=%h required %h", diff, e.diff);
               end
            end
         end
         @(negedge clk);
      end
      testsRun++;
      if (doneCount != 1 || doneCycle != W + 1) begin
         testsFailed++;
         $display("[TB] FAIL ignore_pulses count=%0d cycle=%0d required 1 at %0d", doneCount, doneCycle, W + 1);
      end
   endtask

   task automatic test_reset_mid();
      int   stray = 0;
      exp_t e;
      startOp(8'h77, 8'h11, 1'b0);
      e = sb.pop_front();
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      testsRun++;
      if (busy !== 1'b0 || done !== 1'b0 || diff !== '0 || zero !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL reset_mid busy=%b done=%b diff=%h zero=%b required 0/0/00/0 (dropped %h)",
                  busy, done, diff, zero, e.diff);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 15; c++) begin
         @(negedge clk);
         if (done !== 1'b0 || busy !== 1'b0) stray++;
      end
      testsRun++;
      if (stray != 0) begin
         testsFailed++;
         $display("[TB] FAIL reset_mid_idle stray_cycles=%0d required 0", stray);
      end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] pa[4] = '{8'hC3, 8'h01, 8'h7F, 8'h00};
      logic [W-1:0] pb[4] = '{8'h3C, 8'h02, 8'h80, 8'h00};
      logic         pbi[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      logic [W-1:0] lastDiff = '0;
      exp_t         e;
      for (int k = 0; k < 40; k++) begin
         if (k % 10 == 9) begin
            testsRun++;
            if (done !== 1'b1) begin
               testsFailed++;
               $display("[TB] FAIL b2b_done cycle %0d done=%b required 1", k, done);
            end
            if (sb.size() == 0) begin
               testsRun++;
               testsFailed++;
               $display("[TB] FAIL b2b_queue cycle %0d scoreboard empty required entry", k);
            end else begin
               e = sb.pop_front();
               testsRun++;
               if ({diff, borrow, overflow, zero} !== e) begin
                  testsFailed++;
                  $display("[TB] FAIL b2b_result op%0d diff=%h b=%b o=%b z=%b required diff=%h b=%b o=%b z=%b",
                           k / 10, diff, borrow, overflow, zero, e.diff, e.borrow, e.overflow, e.zero);
               end
            end
            lastDiff = diff;
         end else if (k >= 10) begin
            testsRun++;
            if (done !== 1'b0 || diff !== lastDiff) begin
               testsFailed++;
               $display("[TB] FAIL b2b_hold cycle %0d done=%b diff=%h required 0/%h", k, done, diff, lastDiff);
            end
         end
         start = (k < 39);
         if (k % 10 == 0) begin
            a   = pa[k / 10];
            b   = pb[k / 10];
            bin = pbi[k / 10];
            sb.push_back(model(a, b, bin));
         end else begin
            a   = W'($urandom);
            b   = W'($urandom);
            bin = 1'($urandom);
         end
         @(negedge clk);
      end
      start = 1'b0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_ignore_start();
      test_reset_mid();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Parametrised, bit-serial successor to the 1-bit half subtractor cell.
- Computes `diff = a - b - bin` over WIDTH bits, LSB first, one bit per clock.
- Uses a single full-subtractor slice with a registered borrow. Flags are produced at completion.
- Sits in the arithmetic datapath wherever area matters more than latency; driven by a start/busy/done handshake.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range 2 to 64).
- CNT_W, $clog2(WIDTH)+1, width of the internal bit counter (derived; not overridden by users).

Ports:
- clk, input, 1, system clock; all state updates on rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, request to begin a subtraction; sampled only in IDLE.
- a, input, WIDTH, minuend; captured on the accepted start edge.
- b, input, WIDTH, subtrahend; captured on the accepted start edge.
- bin, input, 1, borrow-in for chaining; captured on the accepted start edge.
- busy, output, 1, high while bits are being processed.
- done, output, 1, single-cycle pulse when the result is valid.
- diff, output, WIDTH, difference; holds the last result until the next accepted start.
- borrow, output, 1, final borrow-out (unsigned a < b + bin).
- overflow, output, 1, signed overflow of a - b - bin (two's complement).
- zero, output, 1, high when diff == 0.

Behaviour:
- Reset (rst_n low, asynchronous): state = IDLE; busy, done, borrow, overflow, zero = 0; diff = 0; counter and internal shift registers = 0. Outputs go low immediately, not at the next edge.
- States:
  - IDLE: start=1 at a rising edge captures a, b, bin into shift registers and moves to SHIFT with counter = 0, borrow register = bin. start=0 stays in IDLE.
  - SHIFT: each edge processes bit i = counter.
    - Slice: d_i = a_i ^ b_i ^ br; br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br).
    - d_i is shifted into the result MSB side; the operand registers shift right.
    - counter increments. When counter == WIDTH-1 at the edge, next state is DONE.
  - DONE: lasts exactly one cycle; done=1. Next edge goes to IDLE.
- Output update: diff, borrow, overflow and zero are updated on the edge entering DONE and hold until the edge entering DONE of the next operation.
- Overflow is computed as (a_msb ^ b_msb) & (a_msb ^ diff_msb), using the captured operands.
- Latency: start high in cycle 0 → busy high in cycles 1..WIDTH → done=1, busy=0 in cycle WIDTH+1. Throughput is one operation per WIDTH+2 cycles.
- busy = (state == SHIFT). done = (state == DONE). They are never high together.
- start while in SHIFT or DONE is ignored; there is no queuing and captured operands are unaffected.
- Changes on a, b or bin after capture have no effect on the current operation.
- Reset mid-operation aborts immediately. No done pulse is produced, and the prior result is cleared to 0.
- Wrap-around: the result is modulo 2^WIDTH. borrow=1 whenever the true difference is negative.

Test Plan (WIDTH=8):
- a=0x35, b=0x12, bin=0, start pulse → done in cycle 9 with diff=0x23, borrow=0, overflow=0, zero=0; busy high in cycles 1–8 only.
- a=0x12, b=0x35, bin=0 → diff=0xDD, borrow=1, overflow=0. Then a=0x80, b=0x01 → diff=0x7F, borrow=0, overflow=1.
- a=0x5A, b=0x5A, bin=0 → diff=0x00, zero=1, borrow=0. Same operands with bin=1 → diff=0xFF, borrow=1, zero=0.
- Start with a=0x40, b=0x10; in cycle 3 drive start=1 with a=0xFF, b=0x00 → ignored. Result is 0x30 at cycle 9, and only one done pulse occurs.
- Start an operation, assert rst_n=0 in cycle 4 (between edges) → busy, done, diff go to 0 immediately. After release, IDLE persists with no done pulse until the next start.
- Back-to-back: hold start=1 continuously → accepts in cycles 0, 10, 20… (IDLE only). Each result is correct, and diff is stable between done pulses.
